// File: rtl/debug_dump_host.sv
// Host end of the debug link: sends one command byte, then gathers the
// streamed dump into a single wide frame.
module debug_dump_host #(
    parameter int DEBUG_W = 322,
    parameter int NBYTES  = 41,
    parameter int TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [7:0]         cmd_byte,
    output logic               cmd_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done_tick,
    input  logic               rx_done_tick,
    input  logic [7:0]         rx_data,
    output logic [DEBUG_W-1:0] frame,
    output logic               frame_valid,
    output logic               timeout_err,
    output logic               busy
);

    localparam int BW = $clog2(NBYTES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RECV,
        DONE
    } state_t;

    state_t state, state_d;

    logic [BW-1:0]      bcnt;
    logic [TW-1:0]      tcnt;
    logic [DEBUG_W-1:0] shadow;
    logic               last_byte;
    logic               tc;

    assign last_byte = (bcnt == BW'(NBYTES - 1));
    assign tc        = (tcnt == TW'(TIMEOUT - 1));
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_d = SEND;
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (tx_done_tick) state_d = RECV;
            RECV: begin
                // An arriving byte takes priority over the terminal count
                if (rx_done_tick) begin
                    if (last_byte) state_d = DONE;
                end else if (tc) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start    <= 1'b0;
            tx_data     <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            bcnt        <= '0;
            tcnt        <= '0;
            shadow      <= '0;
        end else begin
            tx_start    <= 1'b0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: if (cmd_valid) tx_data <= cmd_byte;
                SEND: tx_start <= 1'b1;
                WAIT_TX: begin
                    if (tx_done_tick) begin
                        bcnt <= '0;
                        tcnt <= '0;
                    end
                end
                RECV: begin
                    if (rx_done_tick) begin
                        // Bits of the last byte beyond DEBUG_W fall off here
                        for (int b = 0; b < DEBUG_W; b++) begin
                            if (BW'(b / 8) == bcnt)
                                shadow[b] <= rx_data[3'(b % 8)];
                        end
                        bcnt <= bcnt + 1'b1;
                        tcnt <= '0;
                    end else if (tc) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    frame       <= shadow;
                    frame_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_host.sv
// Directed bench for debug_dump_host: table of dumps plus hand-written
// sequences for timeout, busy rejection, stray bytes and async reset.
module tb_debug_dump_host;

    localparam int DW = 322;
    localparam int NB = 41;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [7:0]    cmd_byte;
    logic          cmd_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done_tick;
    logic          rx_done_tick;
    logic [7:0]    rx_data;
    logic [DW-1:0] frame;
    logic          frame_valid;
    logic          timeout_err;
    logic          busy;

    debug_dump_host #(
        .DEBUG_W(DW),
        .NBYTES (NB),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .cmd_ready   (cmd_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done_tick(tx_done_tick),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .frame       (frame),
        .frame_valid (frame_valid),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txs_cnt = 0;
    int fv_cnt = 0;
    int to_cnt = 0;

    always @(posedge clk) begin
        if (tx_start)    txs_cnt <= txs_cnt + 1;
        if (frame_valid) fv_cnt  <= fv_cnt + 1;
        if (timeout_err) to_cnt  <= to_cnt + 1;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
        logic [7:0] exp_b20;
        logic [1:0] exp_top;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [DW-1:0] exp);
        checks++;
        if (frame !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, frame, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [7:0] base,
                                            input logic [7:0] step);
        logic [NB*8-1:0] f;
        logic [7:0]      b;
        f = '0;
        b = base;
        for (int k = 0; k < NB; k++) begin
            f[8*k +: 8] = b;
            b = b + step;
        end
        return f[DW-1:0];
    endfunction

    task automatic send_cmd(input logic [7:0] c);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_byte  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        chk("send_state", 64'({busy, cmd_ready, tx_start}), 64'b100);
        @(negedge clk);
        chk("tx_start_hi", 64'(tx_start), 64'd1);
        chk("tx_data", 64'(tx_data), 64'(c));
        @(negedge clk);
        chk("tx_start_pulse", 64'(tx_start), 64'd0);
        chk("tx_data_hold", 64'(tx_data), 64'(c));
    endtask

    task automatic tx_done();
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic recv(input logic [7:0] base, input logic [7:0] step,
                        input int n);
        logic [7:0] b;
        b = base;
        for (int k = 0; k < n; k++) begin
            rx_data      = b;
            rx_done_tick = 1'b1;
            @(negedge clk);
            rx_done_tick = 1'b0;
            b = b + step;
        end
    endtask

    task automatic finish_dump(input logic [DW-1:0] expf, input int fv0);
        chk("fv_latency1", 64'(frame_valid), 64'd0);
        @(negedge clk);
        chk("fv_latency2", 64'(frame_valid), 64'd1);
        chk_frame("frame_full", expf);
        @(negedge clk);
        chk("fv_pulse", 64'(frame_valid), 64'd0);
        chk("ready_after", 64'(cmd_ready), 64'd1);
        chk("fv_count", 64'(fv_cnt - fv0), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] prev;
        int t0, f0;

        vecs[0] = '{8'h73, 8'h00, 8'h01, 8'h00, 8'h01, 8'h14, 2'b00};
        vecs[1] = '{8'h63, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 2'b01};
        vecs[2] = '{8'h73, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hEB, 2'b11};
        vecs[3] = '{8'h5A, 8'h03, 8'h10, 8'h03, 8'h13, 8'h43, 2'b11};

        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_byte     = 8'h00;
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({cmd_ready, busy, tx_start, frame_valid,
                             timeout_err}), 64'b10000);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk_frame("rst_frame", '0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send_cmd(vecs[i].cmd);
            chk("busy_wait_tx", 64'(busy), 64'd1);
            tx_done();
            f0 = fv_cnt;
            recv(vecs[i].base, vecs[i].step, NB);
            finish_dump(model(vecs[i].base, vecs[i].step), f0);
            chk("frame_b0", 64'(frame[7:0]), 64'(vecs[i].exp_b0));
            chk("frame_b1", 64'(frame[15:8]), 64'(vecs[i].exp_b1));
            chk("frame_b20", 64'(frame[167:160]), 64'(vecs[i].exp_b20));
            chk("frame_top", 64'(frame[321:320]), 64'(vecs[i].exp_top));
        end
        prev = model(8'h03, 8'h10);

        // Timeout after 10 bytes
        send_cmd(8'h73);
        tx_done();
        t0 = to_cnt;
        recv(8'h40, 8'h01, 10);
        for (int c = 1; c < TO; c++) begin
            @(negedge clk);
            if (timeout_err) chk("timeout_early", 64'(c), 64'(TO));
        end
        @(negedge clk);
        chk("timeout_pulse", 64'(timeout_err), 64'd1);
        chk("timeout_ready", 64'(cmd_ready), 64'd1);
        chk_frame("timeout_frame_kept", prev);
        @(negedge clk);
        chk("timeout_once", 64'(to_cnt - t0), 64'd1);

        // Busy rejection during RECV
        send_cmd(8'h73);
        tx_done();
        t0 = txs_cnt;
        cmd_valid = 1'b1;
        cmd_byte  = 8'h63;
        f0 = fv_cnt;
        recv(8'h11, 8'h02, NB);
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        finish_dump(model(8'h11, 8'h02), f0);
        chk("busy_no_tx", 64'(txs_cnt - t0), 64'd0);
        send_cmd(8'h63);
        tx_done();
        f0 = fv_cnt;
        recv(8'h20, 8'h03, NB);
        finish_dump(model(8'h20, 8'h03), f0);

        // Stray bytes in IDLE and WAIT_TX
        prev = model(8'h20, 8'h03);
        recv(8'hEE, 8'h01, 3);
        @(negedge clk);
        chk_frame("stray_idle_frame", prev);
        chk("stray_idle_state", 64'(cmd_ready), 64'd1);
        send_cmd(8'h73);
        recv(8'hDD, 8'h01, 2);
        chk_frame("stray_wait_frame", prev);
        tx_done();
        f0 = fv_cnt;
        recv(8'h80, 8'h05, NB);
        finish_dump(model(8'h80, 8'h05), f0);

        // Async reset mid-RECV at byte 20
        send_cmd(8'h73);
        tx_done();
        recv(8'h01, 8'h01, 20);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_outs", 64'({cmd_ready, busy, tx_start, frame_valid,
                              timeout_err}), 64'b10000);
        chk("arst_tx_data", 64'(tx_data), 64'd0);
        chk_frame("arst_frame", '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_cmd(8'h73);
        tx_done();
        f0 = fv_cnt;
        recv(8'h30, 8'h07, NB);
        finish_dump(model(8'h30, 8'h07), f0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
